regfile_access_arbiter: RTL

Sequencing controller that shares the 8-entry x 32-bit register file between two requesters (M0, M1). Each request is a single read or write. The block arbitrates round-robin, drives the register-file write port (we/wAddr/wData) and the read-mux address, captures read data, and returns a done pulse. It sits directly in front of the register file's write-operation and read-operation logic; no requester touches the register file directly.

---
 rtl/regfile_access_arbiter_pkg.sv | 17 +
 rtl/regfile_access_arbiter_rr_arb2.sv | 36 +++
 rtl/regfile_access_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/regfile_access_arbiter_pkg.sv
// Shared definitions for the register-file access arbiter: width defaults,
// FSM state encodings and requester identifiers.
package regfile_access_arbiter_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic REQ_M0 = 1'b0;
  localparam logic REQ_M1 = 1'b1;

endpackage

// File: rtl/regfile_access_arbiter_rr_arb2.sv
// Two-way round-robin picker. Purely combinational; the caller owns the
// last_grant register and updates it whenever a grant is issued.
import regfile_access_arbiter_pkg::*;

module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       valid,
  output logic       winner
);

  // Pick the single requester, or on a tie the one not granted last time.
  always_comb begin
    valid  = 1'b0;
    winner = REQ_M0;
    case (req)
      2'b01: begin
        valid  = 1'b1;
        winner = REQ_M0;
      end
      2'b10: begin
        valid  = 1'b1;
        winner = REQ_M1;
      end
      2'b11: begin
        valid  = 1'b1;
        winner = ~last_grant;
      end
      default: begin
        valid  = 1'b0;
        winner = REQ_M0;
      end
    endcase
  end

endmodule

// File: rtl/regfile_access_arbiter.sv
// Sequencing controller sharing one register file between two requesters.
// Each transaction takes three cycles: grant/access, done, back to idle.
// Every output is a flop; the next-state process computes all next values.
import regfile_access_arbiter_pkg::*;

module regfile_access_arbiter #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  m0_req,
  input  logic                  m0_wr,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic                  m1_req,
  input  logic                  m1_wr,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m0_gnt,
  output logic                  m1_gnt,
  output logic                  m0_done,
  output logic                  m1_done,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_wAddr,
  output logic [DATA_WIDTH-1:0] rf_wData,
  output logic [ADDR_WIDTH-1:0] rf_rAddr,
  input  logic [DATA_WIDTH-1:0] rf_rData,
  output logic                  busy
);

  state_t                state_r, state_nxt_s;
  logic                  last_grant_r, last_grant_nxt_s;
  logic                  winner_r, winner_nxt_s;
  logic                  wr_r, wr_nxt_s;
  logic                  m0_gnt_nxt_s, m1_gnt_nxt_s;
  logic                  m0_done_nxt_s, m1_done_nxt_s;
  logic [DATA_WIDTH-1:0] m0_rdata_nxt_s, m1_rdata_nxt_s;
  logic                  rf_we_nxt_s;
  logic [ADDR_WIDTH-1:0] rf_wAddr_nxt_s, rf_rAddr_nxt_s;
  logic [DATA_WIDTH-1:0] rf_wData_nxt_s;
  logic                  busy_nxt_s;

  logic                  arb_valid_s, arb_winner_s;
  logic                  win_wr_s;
  logic [ADDR_WIDTH-1:0] win_addr_s;
  logic [DATA_WIDTH-1:0] win_wdata_s;

  rr_arb2 u_rr_arb2 (
    .req        ({m1_req, m0_req}),
    .last_grant (last_grant_r),
    .valid      (arb_valid_s),
    .winner     (arb_winner_s)
  );

  // Route the winning requester's fields toward the capture registers.
  always_comb begin
    if (arb_winner_s == REQ_M1) begin
      win_wr_s    = m1_wr;
      win_addr_s  = m1_addr;
      win_wdata_s = m1_wdata;
    end else begin
      win_wr_s    = m0_wr;
      win_addr_s  = m0_addr;
      win_wdata_s = m0_wdata;
    end
  end

  // Next-state and next-output logic; every register holds unless changed.
  always_comb begin
    state_nxt_s      = state_r;
    last_grant_nxt_s = last_grant_r;
    winner_nxt_s     = winner_r;
    wr_nxt_s         = wr_r;
    m0_gnt_nxt_s     = 1'b0;
    m1_gnt_nxt_s     = 1'b0;
    m0_done_nxt_s    = 1'b0;
    m1_done_nxt_s    = 1'b0;
    m0_rdata_nxt_s   = m0_rdata;
    m1_rdata_nxt_s   = m1_rdata;
    rf_we_nxt_s      = 1'b0;
    rf_wAddr_nxt_s   = rf_wAddr;
    rf_rAddr_nxt_s   = rf_rAddr;
    rf_wData_nxt_s   = rf_wData;
    busy_nxt_s       = busy;
    case (state_r)
      ST_IDLE: begin
        if (arb_valid_s) begin
          state_nxt_s      = ST_ACCESS;
          last_grant_nxt_s = arb_winner_s;
          winner_nxt_s     = arb_winner_s;
          wr_nxt_s         = win_wr_s;
          m0_gnt_nxt_s     = (arb_winner_s == REQ_M0);
          m1_gnt_nxt_s     = (arb_winner_s == REQ_M1);
          rf_we_nxt_s      = win_wr_s;
          rf_wAddr_nxt_s   = win_addr_s;
          rf_rAddr_nxt_s   = win_addr_s;
          rf_wData_nxt_s   = win_wdata_s;
          busy_nxt_s       = 1'b1;
        end else begin
          busy_nxt_s       = 1'b0;
        end
      end
      ST_ACCESS: begin
        // The register file commits a write on this exiting edge; a read
        // is captured from the combinational read mux on the same edge.
        if (!wr_r) begin
          if (winner_r == REQ_M1) begin
            m1_rdata_nxt_s = rf_rData;
          end else begin
            m0_rdata_nxt_s = rf_rData;
          end
        end else begin
          m0_rdata_nxt_s = m0_rdata;
        end
        m0_done_nxt_s = (winner_r == REQ_M0);
        m1_done_nxt_s = (winner_r == REQ_M1);
        busy_nxt_s    = 1'b1;
        state_nxt_s   = ST_DONE;
      end
      ST_DONE: begin
        busy_nxt_s  = 1'b0;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        busy_nxt_s  = 1'b0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      last_grant_r <= REQ_M1;
      winner_r     <= REQ_M0;
      wr_r         <= 1'b0;
      m0_gnt       <= 1'b0;
      m1_gnt       <= 1'b0;
      m0_done      <= 1'b0;
      m1_done      <= 1'b0;
      m0_rdata     <= {DATA_WIDTH{1'b0}};
      m1_rdata     <= {DATA_WIDTH{1'b0}};
      rf_we        <= 1'b0;
      rf_wAddr     <= {ADDR_WIDTH{1'b0}};
      rf_rAddr     <= {ADDR_WIDTH{1'b0}};
      rf_wData     <= {DATA_WIDTH{1'b0}};
      busy         <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      last_grant_r <= last_grant_nxt_s;
      winner_r     <= winner_nxt_s;
      wr_r         <= wr_nxt_s;
      m0_gnt       <= m0_gnt_nxt_s;
      m1_gnt       <= m1_gnt_nxt_s;
      m0_done      <= m0_done_nxt_s;
      m1_done      <= m1_done_nxt_s;
      m0_rdata     <= m0_rdata_nxt_s;
      m1_rdata     <= m1_rdata_nxt_s;
      rf_we        <= rf_we_nxt_s;
      rf_wAddr     <= rf_wAddr_nxt_s;
      rf_rAddr     <= rf_rAddr_nxt_s;
      rf_wData     <= rf_wData_nxt_s;
      busy         <= busy_nxt_s;
    end
  end

endmodule
